// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port 8 KB RAM between port A (CPU) and port B (loader),
// with an optional post-reset zero-fill and a starvation guard for port B.
module ram_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0]  CLEAR_VALUE    = 8'h00,
  parameter int          MAX_WAIT       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [12:0] a_addr,
  input  logic [7:0]  a_din,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [7:0]  a_dout,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [12:0] b_addr,
  input  logic [7:0]  b_din,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [7:0]  b_dout,
  output logic [12:0] ram_address,
  output logic        ram_w_en,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        clear_busy
);
  typedef enum logic {CLEAR, ARB} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_t      state, state_nx;
  logic [12:0] fill, last_addr;
  logic [3:0]  starve, starve_nx;
  logic        a_win, b_win;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : ARB;
      fill      <= '0;
      starve    <= '0;
      last_addr <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      state     <= state_nx;
      fill      <= (state == CLEAR) ? fill + 13'd1 : fill;
      starve    <= starve_nx;
      last_addr <= ram_address;
      a_rvalid  <= a_win && !a_we;
      b_rvalid  <= b_win && !b_we;
    end
  end
  // B wins outright when alone, or when A has starved it for MAX_WAIT cycles
  always_comb begin
    b_win       = (state == ARB) && b_req && (!a_req || starve == MW);
    a_win       = (state == ARB) && a_req && !b_win;
    state_nx    = (state == CLEAR && fill == 13'h1FFF) ? ARB : state;
    starve_nx   = (b_req && a_win) ? ((starve == MW) ? starve : starve + 4'd1) : 4'd0;
    ram_address = (state == CLEAR) ? fill : a_win ? a_addr : b_win ? b_addr : last_addr;
    ram_w_en    = (state == CLEAR) || (a_win && a_we) || (b_win && b_we);
    ram_din     = (state == CLEAR) ? CLEAR_VALUE : b_win ? b_din : a_din;
  end
  assign a_gnt      = a_win;
  assign b_gnt      = b_win;
  assign a_dout     = ram_dout;
  assign b_dout     = ram_dout;
  assign clear_busy = (state == CLEAR);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with read-data scoreboard queues per port and a RAM model.
module tb_ram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [12:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_din = '0, b_din = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_w_en, clear_busy;
  logic [7:0]  a_dout, b_dout, ram_din;
  logic [7:0]  ram_dout = '0;
  logic [12:0] ram_address;
  logic [7:0]  mem [0:8191];
  logic [7:0]  qa[$], qb[$];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout),
    .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_din(ram_din),
    .ram_dout(ram_dout), .clear_busy(clear_busy)
  );

  // registered-read single-port RAM
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_address] <= ram_din;
    ram_dout <= mem[ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_rvalid) begin
      if (qa.size() == 0) check("a_rvalid_unexpected", 1, 0);
      else check("a_dout", a_dout, qa.pop_front());
    end
    if (rst_n && b_rvalid) begin
      if (qb.size() == 0) check("b_rvalid_unexpected", 1, 0);
      else check("b_dout", b_dout, qb.pop_front());
    end
  end

  initial begin
    int  n;
    bit  seq_ok, gnt_seen;
    repeat (2) @(posedge clk);
    #2;
    check("rst_clear_busy", clear_busy, 1);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_gnt", a_gnt, 0);
    // first fill, interrupted at 0x0800
    cyc; rst_n = 1; #1;
    seq_ok = 1;
    for (int i = 0; i < 2048; i++) begin
      if (!(clear_busy && ram_w_en && ram_address == 13'(i) && ram_din == 8'hA5)) seq_ok = 0;
      cyc; #1;
    end
    check("fill1_seq", seq_ok, 1);
    check("fill1_addr_0800", ram_address, 13'h0800);
    a_req = 1; a_we = 0; a_addr = 13'h1234; rst_n = 0; #1;
    check("midrst_clear_busy", clear_busy, 1);
    check("midrst_addr", ram_address, 0);
    check("midrst_a_gnt", a_gnt, 0);
    cyc; cyc; rst_n = 1; #1;
    // full fill with a_req pending
    n = 0; seq_ok = 1; gnt_seen = 0;
    while (clear_busy && n < 9000) begin
      if (!(ram_w_en && ram_address == 13'(n) && ram_din == 8'hA5)) seq_ok = 0;
      if (a_gnt || b_gnt) gnt_seen = 1;
      cyc; #1; n++;
    end
    check("fill_cycles", n, 8192);
    check("fill_seq", seq_ok, 1);
    check("fill_no_gnt", gnt_seen, 0);
    check("first_arb_a_gnt", a_gnt, 1);
    check("first_arb_addr", ram_address, 13'h1234);
    check("first_arb_we", ram_w_en, 0);
    qa.push_back(8'hA5);
    cyc; a_req = 0; #1;
    check("first_read_a_rvalid", a_rvalid, 1);
    check("first_read_b_rvalid", b_rvalid, 0);
    // contention: A,A,A,A,B repeating
    cyc;
    a_req = 1; a_we = 1; a_addr = 13'h0200; a_din = 8'h01;
    b_req = 1; b_we = 1; b_addr = 13'h0300; b_din = 8'h02;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("cont_a_gnt_%0d", i), a_gnt, (i % 5) != 4);
      check($sformatf("cont_b_gnt_%0d", i), b_gnt, (i % 5) == 4);
      check($sformatf("cont_addr_%0d", i), ram_address, ((i % 5) == 4) ? 13'h0300 : 13'h0200);
      cyc; #1;
    end
    a_req = 0; b_req = 0; #1;
    check("cont_a_rvalid_after_write", a_rvalid, 0);
    check("cont_b_rvalid_after_write", b_rvalid, 0);
    check("idle_w_en", ram_w_en, 0);
    check("idle_addr_hold", ram_address, 13'h0300);
    // B writes, A reads back
    cyc; b_req = 1; b_we = 1; b_addr = 13'h0100; b_din = 8'h3C; #1;
    check("wr_b_gnt", b_gnt, 1);
    check("wr_a_gnt", a_gnt, 0);
    check("wr_w_en", ram_w_en, 1);
    check("wr_addr", ram_address, 13'h0100);
    check("wr_din", ram_din, 8'h3C);
    cyc; b_req = 0; a_req = 1; a_we = 0; a_addr = 13'h0100; #1;
    check("rd_a_gnt", a_gnt, 1);
    qa.push_back(8'h3C);
    cyc; a_req = 0; #1;
    check("rd_a_rvalid", a_rvalid, 1);
    check("rd_b_rvalid", b_rvalid, 0);
    // alternating reads
    cyc; a_req = 1; a_we = 1; a_addr = 13'h0010; a_din = 8'h11; #1;
    check("pre1_a_gnt", a_gnt, 1);
    cyc; a_addr = 13'h0020; a_din = 8'h22; #1;
    cyc; a_we = 0; a_addr = 13'h0010; #1;
    check("alt_a_gnt", a_gnt, 1);
    qa.push_back(8'h11);
    cyc; a_req = 0; b_req = 1; b_we = 0; b_addr = 13'h0020; #1;
    check("alt_b_gnt", b_gnt, 1);
    check("alt_a_rvalid", a_rvalid, 1);
    qb.push_back(8'h22);
    cyc; b_req = 0; #1;
    check("alt_b_rvalid", b_rvalid, 1);
    check("alt_a_rvalid_low", a_rvalid, 0);
    // withdrawn B request must not leave the starvation count behind
    cyc;
    a_req = 1; a_we = 1; a_addr = 13'h0400; a_din = 8'h55;
    b_req = 1; b_we = 1; b_addr = 13'h0500; b_din = 8'h66;
    #1;
    check("wd_a_gnt", a_gnt, 1);
    check("wd_b_gnt", b_gnt, 0);
    cyc; b_req = 0; #1;
    check("wd2_a_gnt", a_gnt, 1);
    check("wd2_b_gnt", b_gnt, 0);
    cyc; b_req = 1; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wd_cont_b_gnt_%0d", i), b_gnt, i == 4);
      check($sformatf("wd_cont_a_gnt_%0d", i), a_gnt, i != 4);
      cyc; #1;
    end
    a_req = 0; b_req = 0; #1;
    check("wd_idle_w_en", ram_w_en, 0);
    check("wd_idle_gnt", {a_gnt, b_gnt}, 0);
    check("wd_idle_addr", ram_address, 13'h0500);
    repeat (2) cyc;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
